// File: rtl/modexp_scheduler.sv
// modexp_scheduler: left-to-right square-and-multiply sequencer for modular
// exponentiation (result = base^exp mod n). It drives one shared external
// modular multiplier over a req/ack handshake and counts the busy cycles.
// Optional build macro CONST_TIME_EN: a multiply follows every square, so the
// multiplier traffic and the cycle count do not depend on the exponent bits.
//
// state  | meaning
// IDLE   | wait for start, latch base/exp/n
// LOAD   | seed accumulator, or finish immediately with err when n==0
// SQR    | request acc*acc, wait for mul_ack
// MUL    | request acc*base, wait for mul_ack
// GAP    | mandatory request-low cycle between multiplier operations
// DONE   | publish result with a one-cycle done pulse
module modexp_scheduler #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   base,
   input  logic [2*WIDTH-1:0]   exp,
   input  logic [2*WIDTH-1:0]   n,
   output logic [2*WIDTH-1:0]   result,
   output logic                 done,
   output logic                 busy,
   output logic                 err,
   output logic [15:0]          cycle_cnt,
   output logic                 mul_req,
   output logic [2*WIDTH-1:0]   mul_a,
   output logic [2*WIDTH-1:0]   mul_b,
   output logic [2*WIDTH-1:0]   mul_n,
   input  logic                 mul_ack,
   input  logic [2*WIDTH-1:0]   mul_p
);

   localparam int NW = 2 * WIDTH;
   localparam int IW = $clog2(NW);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_SQR, S_MUL, S_GAP, S_DONE
   } state_t;

   state_t          state_q, state_d, nxt_q, nxt_d;
   logic [NW-1:0]   base_q, base_d, exp_q, exp_d, n_q, n_d;
   logic [NW-1:0]   acc_q, acc_d, result_q, result_d;
   logic [NW-1:0]   a_q, a_d, b_q, b_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [15:0]     cnt_q, cnt_d;
   logic            done_q, done_d, busy_q, busy_d, err_q, err_d, req_q, req_d;
   logic            do_mul;

   // Next-state and datapath updates; all outputs are derived from state_d so
   // they are registered alongside the state.
   always_comb begin
      state_d  = state_q;
      nxt_d    = nxt_q;
      base_d   = base_q;
      exp_d    = exp_q;
      n_d      = n_q;
      acc_d    = acc_q;
      result_d = result_q;
      a_d      = a_q;
      b_d      = b_q;
      idx_d    = idx_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      do_mul   = 1'b0;

      // Every busy cycle counts, saturating so long operations never wrap.
      if (busy_q && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = base;
               exp_d   = exp;
               n_d     = n;
               acc_d   = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (n_q == '0) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               acc_d   = (n_q == NW'(1)) ? '0 : NW'(1);
               idx_d   = IW'(NW - 1);
               state_d = S_SQR;
            end
         end
         S_SQR: begin
            if (mul_ack) begin
               acc_d   = mul_p;
               state_d = S_GAP;
`ifdef CONST_TIME_EN
               do_mul  = 1'b1;
`else
               do_mul  = exp_q[idx_q];
`endif
               if (do_mul)              nxt_d = S_MUL;
               else if (idx_q == '0)    nxt_d = S_DONE;
               else begin
                  idx_d = idx_q - IW'(1);
                  nxt_d = S_SQR;
               end
            end
         end
         S_MUL: begin
            if (mul_ack) begin
`ifdef CONST_TIME_EN
               // Dummy multiply for zero bits: product is dropped.
               acc_d = exp_q[idx_q] ? mul_p : acc_q;
`else
               acc_d = mul_p;
`endif
               state_d = S_GAP;
               if (idx_q == '0) nxt_d = S_DONE;
               else begin
                  idx_d = idx_q - IW'(1);
                  nxt_d = S_SQR;
               end
            end
         end
         S_GAP:   state_d = nxt_q;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d == S_DONE) result_d = acc_q;
      done_d = (state_d == S_DONE);
      busy_d = (state_d == S_LOAD) || (state_d == S_SQR) ||
               (state_d == S_MUL)  || (state_d == S_GAP);
      req_d  = (state_d == S_SQR) || (state_d == S_MUL);

      // Operands are captured only when a request starts, keeping them stable.
      if (req_d && !req_q) begin
         a_d = acc_d;
         b_d = (state_d == S_SQR) ? acc_d : base_q;
      end
   end

   // State and output registers with synchronous reset that aborts any operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         nxt_q    <= S_IDLE;
         base_q   <= '0;
         exp_q    <= '0;
         n_q      <= '0;
         acc_q    <= '0;
         result_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
         req_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         nxt_q    <= nxt_d;
         base_q   <= base_d;
         exp_q    <= exp_d;
         n_q      <= n_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         a_q      <= a_d;
         b_q      <= b_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
         req_q    <= req_d;
      end
   end

   assign result    = result_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign err       = err_q;
   assign cycle_cnt = cnt_q;
   assign mul_req   = req_q;
   assign mul_a     = a_q;
   assign mul_b     = b_q;
   assign mul_n     = n_q;

endmodule

// File: tb/tb_modexp_scheduler.sv
// Directed bench for modexp_scheduler with a mock modular multiplier whose
// ack latency L is adjustable per operation.
module tb_modexp_scheduler;

`ifdef CONST_TIME_EN
   localparam bit CT = 1'b1;
`else
   localparam bit CT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] base_i = '0, exp_i = '0, n_i = '0;
   logic [15:0] result, mul_a, mul_b, mul_n, mul_p, cycle_cnt;
   logic        done, busy, err, mul_req, mul_ack;

   int n_cmp = 0;
   int n_bad = 0;

   int lat = 1;
   int hi_cnt = 0;
   logic force_ack = 1'b0;

   logic        prev_req = 1'b0, prev_ack = 1'b0;
   logic [15:0] prev_a = '0, prev_b = '0;
   int viol_stable = 0, viol_gap = 0, req_rises = 0;

   always #5 clk = ~clk;

   modexp_scheduler #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .base(base_i), .exp(exp_i), .n(n_i),
      .result(result), .done(done), .busy(busy), .err(err), .cycle_cnt(cycle_cnt),
      .mul_req(mul_req), .mul_a(mul_a), .mul_b(mul_b), .mul_n(mul_n),
      .mul_ack(mul_ack), .mul_p(mul_p)
   );

   // Mock multiplier: ack on the lat-th cycle of mul_req high.
   assign mul_ack = (mul_req && (hi_cnt == lat - 1)) || force_ack;
   assign mul_p   = force_ack ? 16'h1234 :
                    (mul_n == '0) ? 16'h0 :
                    16'((32'(mul_a) * 32'(mul_b)) % 32'(mul_n));

   always @(posedge clk) begin
      if (mul_req && !mul_ack) hi_cnt <= hi_cnt + 1;
      else                     hi_cnt <= 0;
   end

   // Handshake protocol monitor.
   always @(negedge clk) begin
      if (mul_req && prev_req && !prev_ack && (mul_a != prev_a || mul_b != prev_b))
         viol_stable++;
      if (prev_ack && mul_req) viol_gap++;
      if (mul_req && !prev_req) req_rises++;
      prev_req = mul_req;
      prev_ack = mul_ack;
      prev_a   = mul_a;
      prev_b   = mul_b;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   task automatic run_op(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                         input int l, input int restart_at,
                         output logic [15:0] r, output logic er,
                         output logic [15:0] cc, output int reqs);
      logic got;
      lat = l;
      @(negedge clk);
      req_rises = 0;
      base_i = b; exp_i = e; n_i = m; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got = 1'b0;
      for (int k = 0; k < 6000 && !got; k++) begin
         @(negedge clk);
         if (done) got = 1'b1;
         else if (k == restart_at) begin
            start = 1'b1; base_i = 16'd7; exp_i = 16'd3; n_i = 16'd11;
         end else start = 1'b0;
      end
      start = 1'b0;
      if (!got) chk("done_timeout", 0, 1);
      r = result; er = err; cc = cycle_cnt; reqs = req_rises;
      chk("busy_at_done", {31'd0, busy}, 0);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done}, 0);
      chk("result_held", {16'd0, result}, {16'd0, r});
   endtask

   logic [15:0] r, cc;
   logic        er;
   int          reqs;
   logic        got_rise;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_outputs", {result, cycle_cnt}, 0);
      chk("rst_flags", {28'd0, done, busy, err, mul_req}, 0);
      rst = 1'b0;

      // 1. decrypt
      run_op(16'd2790, 16'd2753, 16'd3233, 1, -1, r, er, cc, reqs);
      chk("dec_result", r, 65);
      chk("dec_err", {31'd0, er}, 0);
      chk("dec_cnt", cc, CT ? 65 : 43);

      // 2. encrypt
      run_op(16'd65, 16'd17, 16'd3233, 1, -1, r, er, cc, reqs);
      chk("enc_result", r, 2790);
      chk("enc_cnt", cc, CT ? 65 : 37);

      // 3. edge moduli / exponents
      run_op(16'd5, 16'd0, 16'd3233, 1, -1, r, er, cc, reqs);
      chk("exp0_result", r, 1);
      chk("exp0_cnt", cc, CT ? 65 : 33);
      run_op(16'd0, 16'd5, 16'd1, 1, -1, r, er, cc, reqs);
      chk("n1_result", r, 0);
      chk("n1_cnt", cc, CT ? 65 : 37);
      run_op(16'd3, 16'd5, 16'd0, 1, -1, r, er, cc, reqs);
      chk("n0_result", r, 0);
      chk("n0_err", {31'd0, er}, 1);
      chk("n0_cnt", cc, 1);
      chk("n0_no_req", reqs, 0);

      // 4. longer multiplier latency
      run_op(16'd2790, 16'd2753, 16'd3233, 3, -1, r, er, cc, reqs);
      chk("l3_result", r, 65);
      chk("l3_err_cleared", {31'd0, er}, 0);
      chk("l3_cnt", cc, CT ? 129 : 85);
      chk("l3_reqs", reqs, CT ? 32 : 21);
      chk("l3_operand_stable", viol_stable, 0);
      chk("l3_req_gap", viol_gap, 0);

      // 5. start mid-operation ignored; spurious ack in IDLE ignored
      run_op(16'd65, 16'd17, 16'd3233, 1, 10, r, er, cc, reqs);
      chk("restart_result", r, 2790);
      chk("restart_cnt", cc, CT ? 65 : 37);
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack_flags", {29'd0, busy, mul_req, done}, 0);
      chk("idle_ack_result", result, 2790);

      // 6. reset during the first MUL wait (exp MSB set, L=3)
      lat = 3;
      req_rises = 0;
      base_i = 16'd65; exp_i = 16'h8000; n_i = 16'd3233; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      got_rise = 1'b0;
      for (int k = 0; k < 200 && !got_rise; k++) begin
         @(negedge clk);
         if (req_rises >= 2) got_rise = 1'b1;
      end
      if (!got_rise) chk("mul_wait_timeout", 0, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_data", {result, cycle_cnt}, 0);
      chk("abort_ops", {mul_a, mul_b}, 0);
      chk("abort_n", mul_n, 0);
      chk("abort_flags", {28'd0, done, busy, err, mul_req}, 0);
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      @(negedge clk);
      chk("abort_late_ack", {29'd0, busy, mul_req, done}, 0);
      run_op(16'd65, 16'd17, 16'd3233, 1, -1, r, er, cc, reqs);
      chk("post_rst_result", r, 2790);
      chk("post_rst_cnt", cc, CT ? 65 : 37);
      chk("final_operand_stable", viol_stable, 0);
      chk("final_req_gap", viol_gap, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
